// File: rtl/uart_tx_serializer.sv
// UART transmit shift stage: pops one character per frame from the TX buffers and
// serialises start, 5-8 data bits (LSB first), optional parity and 1/1.5/2 stop bits.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_fifo_empty,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       tsr_load,
  output logic       txd,
  output logic       tsr_empty
);

  // Wide enough to count the longest (two-bit) stop period.
  localparam int TW = $clog2(2 * OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    bit_reg, bit_next;
  logic [1:0]    wls_reg, wls_next;
  logic          stb_reg, stb_next;
  logic          pen_reg, pen_next;
  logic          parity_reg, parity_next;
  logic          tsr_load_reg, txd_reg, tsr_empty_reg;

  logic          load;
  logic          line;
  logic          tick_last;
  logic          stop_last;
  logic [TW-1:0] stop_end;
  logic [2:0]    last_bit;
  logic [7:0]    data_masked;
  logic          parity_calc;

  // Bits above the selected word length do not contribute to parity.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      if (gi < 5) begin : g_always
        assign data_masked[gi] = tx_data[gi];
      end else begin : g_optional
        assign data_masked[gi] = tx_data[gi] & (wls >= 2'(gi - 4));
      end
    end
  endgenerate

  assign parity_calc = sp ? ~eps : (eps ? ^data_masked : ~^data_masked);
  assign last_bit    = {1'b0, wls_reg} + 3'd4;
  assign tick_last   = (tick_reg == TW'(OVERSAMPLE - 1));
  assign stop_last   = (tick_reg == stop_end);

  always_comb begin
    stop_end = TW'(OVERSAMPLE - 1);
    if (stb_reg) begin
      if (wls_reg == 2'b00) stop_end = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
      else                  stop_end = TW'(2 * OVERSAMPLE - 1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    tick_next   = tick_reg;
    bit_next    = bit_reg;
    wls_next    = wls_reg;
    stb_next    = stb_reg;
    pen_next    = pen_reg;
    parity_next = parity_reg;
    load        = 1'b0;
    line        = 1'b1;

    case (state_reg)
      IDLE: begin
        if (!tx_fifo_empty) begin
          load        = 1'b1;
          state_next  = START;
          shift_next  = tx_data;
          wls_next    = wls;
          stb_next    = stb;
          pen_next    = pen;
          parity_next = parity_calc;
          tick_next   = '0;
          bit_next    = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_last) begin
            tick_next  = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_last) begin
            tick_next  = '0;
            shift_next = {1'b0, shift_reg[7:1]};
            if (bit_reg == last_bit) begin
              bit_next   = '0;
              state_next = pen_reg ? PARITY : STOP;
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (tick_last) begin
            tick_next  = '0;
            state_next = STOP;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_last) begin
            tick_next  = '0;
            state_next = IDLE;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Line level follows the state being entered so txd stays a pure register.
    case (state_next)
      START:   line = 1'b0;
      DATA:    line = shift_next[0];
      PARITY:  line = parity_next;
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      tick_reg      <= '0;
      bit_reg       <= '0;
      wls_reg       <= '0;
      stb_reg       <= 1'b0;
      pen_reg       <= 1'b0;
      parity_reg    <= 1'b0;
      tsr_load_reg  <= 1'b0;
      txd_reg       <= 1'b1;
      tsr_empty_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      tick_reg      <= tick_next;
      bit_reg       <= bit_next;
      wls_reg       <= wls_next;
      stb_reg       <= stb_next;
      pen_reg       <= pen_next;
      parity_reg    <= parity_next;
      tsr_load_reg  <= load;
      txd_reg       <= line & ~bc;
      tsr_empty_reg <= (state_next == IDLE);
    end
  end

  assign tsr_load  = tsr_load_reg;
  assign txd       = txd_reg;
  assign tsr_empty = tsr_empty_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frames are described as hand-written
// bit strings in send order and checked cycle by cycle on the falling edge.
module tb_uart_tx_serializer;

  localparam int OS = 16;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_fifo_empty;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, bc;
  logic       tsr_load, txd, tsr_empty;

  int vectors     = 0;
  int miscompares = 0;
  int load_cnt    = 0;
  int wr_ptr      = 0;
  int rd_ptr      = 0;
  logic [7:0] fifo_mem [0:15];
  logic       found;

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .baud_tick     (baud_tick),
    .tx_data       (tx_data),
    .tx_fifo_empty (tx_fifo_empty),
    .wls           (wls),
    .stb           (stb),
    .pen           (pen),
    .eps           (eps),
    .sp            (sp),
    .bc            (bc),
    .tsr_load      (tsr_load),
    .txd           (txd),
    .tsr_empty     (tsr_empty)
  );

  always #5 pclk = ~pclk;

  // Small buffer model: head is visible while non-empty, popped on tsr_load.
  assign tx_fifo_empty = (wr_ptr == rd_ptr);
  assign tx_data       = fifo_mem[rd_ptr % 16];

  always @(posedge pclk) begin
    if (tsr_load) begin
      rd_ptr   <= rd_ptr + 1;
      load_cnt <= load_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] ch);
    fifo_mem[wr_ptr % 16] = ch;
    wr_ptr++;
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  task automatic wait_load(input string tag, input int wait_max, output logic seen);
    seen = 1'b0;
    for (int w = 0; w < wait_max && !seen; w++) begin
      @(negedge pclk);
      if (tsr_load === 1'b1) seen = 1'b1;
    end
    check({tag, " load seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge pclk);
    check({tag, " idle txd"}, {31'd0, txd}, 32'd1);
    check({tag, " idle tsr_empty"}, {31'd0, tsr_empty}, 32'd1);
    check({tag, " idle tsr_load"}, {31'd0, tsr_load}, 32'd0);
  endtask

  // seq: start/data/parity bits in send order; stop_ticks: stop length in ticks.
  // Break is raised after cycle brk_on and dropped after cycle brk_off.
  task automatic run_frame(input string tag, input string seq, input int stop_ticks,
                           input int wait_max, input int brk_on, input int brk_off);
    logic seen;
    logic exp_txd;
    int   nb;
    int   len;
    nb  = seq.len() * OS;
    len = nb + stop_ticks;
    wait_load(tag, wait_max, seen);
    if (!seen) return;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge pclk);
      exp_txd = (i < nb) ? (seq[i / OS] == 8'h31) : 1'b1;
      if (i > brk_on && i <= brk_off) exp_txd = 1'b0;
      check($sformatf("%s[%0d] txd", tag, i), {31'd0, txd}, {31'd0, exp_txd});
      check($sformatf("%s[%0d] tsr_empty", tag, i), {31'd0, tsr_empty}, 32'd0);
      check($sformatf("%s[%0d] tsr_load", tag, i), {31'd0, tsr_load}, {31'd0, (i == 0)});
      if (i == brk_on)  bc = 1'b1;
      if (i == brk_off) bc = 1'b0;
    end
    $display("frame %s: %0d cycles checked", tag, len);
  endtask

  initial begin
    presetn   = 1'b0;
    baud_tick = 1'b1;
    bc        = 1'b0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge pclk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset tsr_empty", {31'd0, tsr_empty}, 32'd1);
    check("reset tsr_load", {31'd0, tsr_load}, 32'd0);
    presetn = 1'b1;
    check_idle("post-reset");
    check_idle("post-reset2");

    // 8N1 0xA5
    push(8'hA5);
    run_frame("8N1_A5", "010100101", 16, 4, -1, -1);
    check_idle("8N1_A5 end");

    // 7E1 0x41, config disturbed mid-frame must not matter
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h41);
    fork
      run_frame("7E1_41", "010000010", 16, 4, -1, -1);
      begin
        repeat (30) @(negedge pclk);
        wls = 2'b00;
        pen = 1'b0;
      end
    join
    check_idle("7E1_41 end");

    // 5E1 0xE1: upper bits excluded from parity
    set_cfg(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'hE1);
    run_frame("5E1_E1", "0100001", 16, 4, -1, -1);
    check_idle("5E1_E1 end");

    // 5-bit, 1.5 stop bits
    set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    run_frame("5N15_1F", "011111", 24, 4, -1, -1);
    check_idle("5N15_1F end");

    // 8-bit, 2 stop bits
    set_cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    run_frame("8N2_1F", "011111000", 32, 4, -1, -1);
    check_idle("8N2_1F end");

    // Stick parity
    set_cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    push(8'h00);
    run_frame("stick_eps0", "0000000001", 16, 4, -1, -1);
    check_idle("stick_eps0 end");
    set_cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    push(8'h00);
    run_frame("stick_eps1", "0000000000", 16, 4, -1, -1);
    check_idle("stick_eps1 end");

    // Three characters queued back to back, 8N1
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h35);
    push(8'hCA);
    push(8'h0F);
    run_frame("b2b_35", "010101100", 16, 4, -1, -1);
    check_idle("b2b gap1");
    run_frame("b2b_CA", "001010011", 16, 1, -1, -1);
    check_idle("b2b gap2");
    run_frame("b2b_0F", "011110000", 16, 1, -1, -1);
    check_idle("b2b end");

    // Reset during data bit 3 of 0x52 with another character waiting
    push(8'h52);
    push(8'h3C);
    wait_load("rst_52", 4, found);
    repeat (70) @(negedge pclk);
    check("rst_52 bit3 txd", {31'd0, txd}, 32'd0);
    check("rst_52 bit3 tsr_empty", {31'd0, tsr_empty}, 32'd0);
    #2 presetn = 1'b0;
    #1;
    check("rst async txd", {31'd0, txd}, 32'd1);
    check("rst async tsr_empty", {31'd0, tsr_empty}, 32'd1);
    check("rst async tsr_load", {31'd0, tsr_load}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      check($sformatf("rst hold[%0d] tsr_load", k), {31'd0, tsr_load}, 32'd0);
      check($sformatf("rst hold[%0d] txd", k), {31'd0, txd}, 32'd1);
    end
    presetn = 1'b1;
    run_frame("rst_recover_3C", "000111100", 16, 4, -1, -1);
    check_idle("rst_recover end");

    // Break in the middle of the data bits
    push(8'h96);
    run_frame("brk_96", "001101001", 16, 4, 40, 70);
    check_idle("brk_96 end");

    check("total tsr_load pulses", load_cnt, 32'd13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit shift stage (TSR) directly downstream of the UART TX buffers (THR/TX FIFO). It pops one character per frame from the buffers via a single-cycle tsr_load strobe, then serialises it LSB-first on txd. Each frame carries a start bit, 5–8 data bits, optional parity, and 1, 1.5 or 2 stop bits. Bit timing comes from a baud-rate-generator enable pulse at OVERSAMPLE× the bit rate.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period (even, ≥4)

Ports:
pclk  input  1  system clock; all logic on rising edge
presetn  input  1  asynchronous active-low reset
baud_tick  input  1  one-pclk enable pulse, OVERSAMPLE per bit period
tx_data  input  8  head-of-buffer character; valid whenever tx_fifo_empty=0
tx_fifo_empty  input  1  THR/TX FIFO has no character
wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
stb  input  1  0=1 stop bit; 1=2 stop bits (1.5 when wls=00)
pen  input  1  parity enable
eps  input  1  even parity select
sp  input  1  stick parity
bc  input  1  break control; forces txd low
tsr_load  output  1  read strobe to buffers; one pclk wide
txd  output  1  serial output, idle high
tsr_empty  output  1  high when no frame in progress (TEMT)

Behaviour:
- Reset (asynchronous, presetn=0): state=IDLE, txd=1, tsr_load=0, tsr_empty=1, tick and bit counters=0. Effective immediately, including mid-frame. The partially sent character is lost, and no further tsr_load is issued until reset is released.
- States: IDLE, START, DATA, PARITY, STOP.
- Registered outputs: txd and tsr_load are registered. txd = shift-stage value AND NOT bc.
- IDLE:
  - When tx_fifo_empty=0, assert tsr_load for exactly one cycle.
  - In that same cycle, capture tx_data[7:0] into the shift register and latch wls/stb/pen/eps/sp.
  - Next cycle: enter START. Clear tick_cnt and bit_cnt; tsr_empty=0.
- Config changes mid-frame have no effect on the frame in progress.
- Bit period: tick_cnt increments on each baud_tick. The bit ends on the baud_tick where tick_cnt==OVERSAMPLE-1, and tick_cnt wraps to 0. Cycles without baud_tick hold all state.
- START: txd=0 for one bit period, then DATA.
- DATA:
  - txd = shift_reg[0]; shift right at each bit end.
  - After (wls+5) bits: go to PARITY if pen=1, else STOP.
- PARITY: txd for one bit period, then STOP. Bit value:
  - sp=0, eps=1: XOR of the transmitted data bits (even parity).
  - sp=0, eps=0: inverse of that XOR (odd parity).
  - sp=1: the constant NOT eps.
  - Bits above the word length are excluded from the parity calculation.
- STOP: txd=1. Duration:
  - 1×OVERSAMPLE ticks when stb=0.
  - 1.5×OVERSAMPLE when stb=1 and wls=00.
  - 2×OVERSAMPLE otherwise.
  - At the last stop tick, go to IDLE with tsr_empty=1.
- Back-to-back frames: the IDLE cycle following STOP may immediately assert tsr_load. This gives a one-pclk idle gap between frames, and txd stays 1 through it.
- tsr_load is never asserted outside IDLE or while tx_fifo_empty=1. Never two consecutive cycles.
- Break (bc=1): txd=0 regardless of state. The state machine and the pops continue normally. When bc clears, txd resumes the current state's value on the next cycle.
- tsr_empty=0 from START entry through the last stop tick.

Test Plan:
- 8N1, baud_tick every cycle, one character 0xA5 (wls=11, pen=0, stb=0): exactly one tsr_load pulse.
  - txd = 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles (160 cycles total).
  - tsr_empty=1 afterwards.
- 7E1, 0x41 (wls=10, pen=1, eps=1): data bits 1,0,0,0,0,0,1; parity=0; one stop bit. Total frame 160 ticks.
- 5-bit, stb=1, 0x1F (wls=00): 5 data ones, then stop=1 for 24 ticks. Repeat with wls=11, stb=1 and confirm 32-tick stop.
- Stick parity (pen=1, sp=1, eps=0) on 0x00 with 8 bits: parity bit=1. With eps=1: parity bit=0.
- Three characters queued: exactly 3 tsr_load pulses, one per frame. Only a 1-cycle txd-high gap between frames. Bit order preserved.
- Reset and break:
  - Assert presetn=0 during DATA bit 3: txd=1 and tsr_empty=1 immediately, no tsr_load while in reset.
  - After release, the next character transmits cleanly.
  - Separately, bc=1 mid-frame: txd=0 for its duration; frame timing is unchanged.
